tdm_frame_sequencer: RTL and testbench

//  Sequential front-end for the 4:1 MUX / 1:4 DEMUX datapath. It snapshots four channel words,

---
 rtl/tdm_pkg.sv | 18 +
 rtl/tdm_sel_counter.sv | 31 +++
 rtl/tdm_frame_sequencer.sv | 145 ++++++++++++++
 tb/tb_tdm_frame_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM frame sequencer.
package tdm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  // One-hot slot enable, the same decode a 1:4 demux applies to its select.
  function automatic logic [NCH-1:0] slot_onehot(input logic [SEL_W-1:0] sel);
    slot_onehot = 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/tdm_sel_counter.sv
// Two-bit channel select counter with clear priority and a last-channel flag.
module tdm_sel_counter
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [SEL_W-1:0] sel,
  output logic             last
);

  logic [SEL_W-1:0] sel_r;

  // Select register; wraps 3 -> 0 so it is already back at 0 on frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r <= 2'd0;
    end else if (clr) begin
      sel_r <= 2'd0;
    end else if (en) begin
      sel_r <= sel_r + 2'd1;
    end else begin
      sel_r <= sel_r;
    end
  end

  assign sel  = sel_r;
  assign last = (sel_r == 2'd3);

endmodule

// File: rtl/tdm_frame_sequencer.sv
// Snapshots four channel words and scans them onto a serial bus, one per cycle,
// writing each bus word back into its receive slot to form one TDM frame.
module tdm_frame_sequencer #(
  parameter int DATA_W = 8,
  parameter int NCH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                hold_i,
  input  logic [NCH*DATA_W-1:0] ch_i,
  output logic [1:0]          sel_o,
  output logic [DATA_W-1:0]   bus_o,
  output logic                bus_vld_o,
  output logic [NCH*DATA_W-1:0] rx_o,
  output logic                busy_o,
  output logic                done_o
);

  import tdm_pkg::state_t;
  import tdm_pkg::IDLE;
  import tdm_pkg::SCAN;
  import tdm_pkg::DONE;
  import tdm_pkg::SEL_W;
  import tdm_pkg::slot_onehot;

  if (NCH != tdm_pkg::NCH) begin : g_nch_check
    $error("tdm_frame_sequencer: NCH must be 4 (2-bit select)");
  end

  state_t                  state_r, state_nxt;
  logic [NCH*DATA_W-1:0]   snap_r, snap_nxt;
  logic [NCH*DATA_W-1:0]   rx_r, rx_nxt;
  logic [DATA_W-1:0]       bus_r, bus_nxt;
  logic                    busy_r, done_r;
  logic [SEL_W-1:0]        sel, sel_nxt;
  logic                    last, cnt_clr, cnt_en, load;
  logic [NCH-1:0]          rx_we;

  tdm_sel_counter u_sel_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .sel   (sel),
    .last  (last)
  );

  // Next-state, demux write decode and next output values.
  always_comb begin
    state_nxt = state_r;
    load      = 1'b0;
    cnt_en    = 1'b0;
    rx_we     = '0;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          load      = 1'b1;
          state_nxt = SCAN;
        end else begin
          state_nxt = IDLE;
        end
      end
      SCAN: begin
        if (!hold_i) begin
          cnt_en = 1'b1;
          rx_we  = slot_onehot(sel);
          if (last) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SCAN;
          end
        end else begin
          state_nxt = SCAN;
        end
      end
      DONE: begin
        if (start_i) begin
          load      = 1'b1;
          state_nxt = SCAN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    cnt_clr = (state_r != SCAN);
    if (cnt_en) begin
      sel_nxt = sel + 2'd1;
    end else if (cnt_clr) begin
      sel_nxt = 2'd0;
    end else begin
      sel_nxt = sel;
    end

    snap_nxt = load ? ch_i : snap_r;

    rx_nxt = rx_r;
    for (int k = 0; k < NCH; k++) begin
      if (rx_we[k]) begin
        rx_nxt[k*DATA_W +: DATA_W] = snap_r[k*DATA_W +: DATA_W];
      end else begin
        rx_nxt[k*DATA_W +: DATA_W] = rx_r[k*DATA_W +: DATA_W];
      end
    end

    // Bus is registered, so it looks ahead at the snapshot it will present next.
    if (state_nxt == SCAN) begin
      bus_nxt = snap_nxt[int'(sel_nxt)*DATA_W +: DATA_W];
    end else begin
      bus_nxt = '0;
    end
  end

  // State, snapshot, receive slots and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      snap_r  <= '0;
      rx_r    <= '0;
      bus_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      snap_r  <= snap_nxt;
      rx_r    <= rx_nxt;
      bus_r   <= bus_nxt;
      busy_r  <= (state_nxt == SCAN);
      done_r  <= (state_nxt == DONE);
    end
  end

  assign sel_o  = sel;
  assign bus_o  = bus_r;
  assign rx_o   = rx_r;
  assign busy_o = busy_r;
  assign done_o = done_r;
  // Valid flags the current word as consumed this cycle, so it tracks hold_i directly.
  assign bus_vld_o = busy_r & ~hold_i;

endmodule

// File: tb/tb_tdm_frame_sequencer.sv
// Directed bench for tdm_frame_sequencer with hand-computed expected frames.
module tb_tdm_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        hold_i;
  logic [31:0] ch_i;
  logic [1:0]  sel_o;
  logic [7:0]  bus_o;
  logic        bus_vld_o;
  logic [31:0] rx_o;
  logic        busy_o;
  logic        done_o;

  int vectors     = 0;
  int miscompares = 0;

  tdm_frame_sequencer #(.DATA_W(8), .NCH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .hold_i    (hold_i),
    .ch_i      (ch_i),
    .sel_o     (sel_o),
    .bus_o     (bus_o),
    .bus_vld_o (bus_vld_o),
    .rx_o      (rx_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_scan(input string tag, input logic [1:0] s, input logic [7:0] b,
                            input logic v);
    check_eq({tag, "_sel"},  {30'd0, sel_o}, {30'd0, s});
    check_eq({tag, "_bus"},  {24'd0, bus_o}, {24'd0, b});
    check_eq({tag, "_vld"},  {31'd0, bus_vld_o}, {31'd0, v});
    check_eq({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
    check_eq({tag, "_done"}, {31'd0, done_o}, 32'd0);
  endtask

  task automatic check_done(input string tag, input logic [31:0] rx);
    check_eq({tag, "_done"}, {31'd0, done_o}, 32'd1);
    check_eq({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check_eq({tag, "_bus"},  {24'd0, bus_o}, 32'd0);
    check_eq({tag, "_sel"},  {30'd0, sel_o}, 32'd0);
    check_eq({tag, "_rx"},   rx_o, rx);
  endtask

  task automatic check_idle(input string tag, input logic [31:0] rx);
    check_eq({tag, "_done"}, {31'd0, done_o}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check_eq({tag, "_vld"},  {31'd0, bus_vld_o}, 32'd0);
    check_eq({tag, "_bus"},  {24'd0, bus_o}, 32'd0);
    check_eq({tag, "_sel"},  {30'd0, sel_o}, 32'd0);
    check_eq({tag, "_rx"},   rx_o, rx);
  endtask

  logic [7:0] fa [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] fb [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
  logic [7:0] fd [4] = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};

  initial begin
    rst_n   = 1'b0;
    start_i = 1'b0;
    hold_i  = 1'b0;
    ch_i    = 32'h0;
    #2;
    check_idle("rst0", 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_idle("rst0_rel", 32'h0);

    // Basic frame
    ch_i = 32'h44332211; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_scan($sformatf("basic%0d", i), 2'(i), fa[i], 1'b1);
      tick();
    end
    check_done("basic_done", 32'h44332211);
    tick();
    check_idle("basic_idle", 32'h44332211);

    // Hold at sel=2 for three cycles; slot 2 keeps its old value until released
    ch_i = 32'h48372615; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_scan("hold_s0", 2'd0, 8'h15, 1'b1);
    tick();
    check_scan("hold_s1", 2'd1, 8'h26, 1'b1);
    tick();
    for (int h = 0; h < 3; h++) begin
      hold_i = 1'b1;
      #1;
      check_scan($sformatf("hold_h%0d", h), 2'd2, 8'h37, 1'b0);
      check_eq($sformatf("hold_h%0d_rx", h), rx_o, 32'h44332615);
      tick();
    end
    hold_i = 1'b0;
    #1;
    check_scan("hold_rel", 2'd2, 8'h37, 1'b1);
    check_eq("hold_rel_rx", rx_o, 32'h44332615);
    tick();
    check_scan("hold_s3", 2'd3, 8'h48, 1'b1);
    check_eq("hold_s3_rx", rx_o, 32'h44372615);
    tick();
    check_done("hold_done", 32'h48372615);
    tick();

    // Input isolation and ignored start during SCAN
    ch_i = 32'h44332211; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_scan("iso0", 2'd0, 8'h11, 1'b1);
    tick();
    ch_i = 32'hFFFFFFFF; start_i = 1'b1;
    check_scan("iso1", 2'd1, 8'h22, 1'b1);
    tick();
    start_i = 1'b0;
    check_scan("iso2", 2'd2, 8'h33, 1'b1);
    tick();
    check_scan("iso3", 2'd3, 8'h44, 1'b1);
    tick();
    check_done("iso_done", 32'h44332211);
    tick();
    check_idle("iso_idle", 32'h44332211);

    // Back-to-back frames with start held high
    ch_i = 32'h44332211; start_i = 1'b1;
    tick();
    ch_i = 32'hA4A3A2A1;
    for (int i = 0; i < 4; i++) begin
      check_scan($sformatf("b2b_a%0d", i), 2'(i), fa[i], 1'b1);
      tick();
    end
    check_done("b2b_done1", 32'h44332211);
    tick();
    for (int i = 0; i < 4; i++) begin
      check_scan($sformatf("b2b_b%0d", i), 2'(i), fb[i], 1'b1);
      tick();
    end
    check_done("b2b_done2", 32'hA4A3A2A1);
    start_i = 1'b0;
    tick();
    check_idle("b2b_idle", 32'hA4A3A2A1);

    // Reset mid-scan at sel=1, then a clean frame
    ch_i = 32'hD4D3D2D1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_scan("mrst0", 2'd0, fd[0], 1'b1);
    tick();
    check_scan("mrst1", 2'd1, fd[1], 1'b1);
    rst_n = 1'b0;
    #1;
    check_idle("mrst_async", 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    check_idle("mrst_rel", 32'h0);
    ch_i = 32'h44332211; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_scan($sformatf("post%0d", i), 2'(i), fa[i], 1'b1);
      tick();
    end
    check_done("post_done", 32'h44332211);
    tick();
    check_idle("post_idle", 32'h44332211);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
